// File: rtl/input_conditioner_pkg.sv
// Shared types for the input conditioner: key FSM states, key indices, selection record and decode.
package input_conditioner_pkg;

  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} key_state_e;

  localparam int KEY_RETURN   = 0;
  localparam int KEY_ZOOM_OUT = 1;
  localparam int KEY_ZOOM_IN  = 2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;

  typedef struct packed {
    logic [1:0] algorithm_select;
    logic       multiple_switches_error;
    logic       no_switch_selected_error;
  } sel_t;

  localparam sel_t SEL_RESET = '{algorithm_select: 2'b00,
                                 multiple_switches_error: 1'b0,
                                 no_switch_selected_error: 1'b1};

  // Lowest-numbered switch wins; an all-low bank falls back to algorithm 0.
  function automatic sel_t decode_sel(input logic [3:0] s);
    sel_t r;
    if (s[0])      r.algorithm_select = 2'b00;
    else if (s[1]) r.algorithm_select = 2'b01;
    else if (s[2]) r.algorithm_select = 2'b10;
    else if (s[3]) r.algorithm_select = 2'b11;
    else           r.algorithm_select = 2'b00;
    r.multiple_switches_error  = ($countones(s) > 1);
    r.no_switch_selected_error = (s == 4'b0000);
    return r;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-input side of the conditioner: raw keys/switches in, commands and selection out.
interface input_conditioner_if;
  logic [2:0] key_n;
  logic [3:0] sw;
  logic       return_pulse;
  logic       zoom_out_pulse;
  logic       zoom_in_pulse;
  logic [1:0] algorithm_select;
  logic       multiple_switches_error;
  logic       no_switch_selected_error;
  logic       sel_changed;

  modport master (
    output key_n, sw,
    input  return_pulse, zoom_out_pulse, zoom_in_pulse,
    input  algorithm_select, multiple_switches_error, no_switch_selected_error, sel_changed
  );

  modport slave (
    input  key_n, sw,
    output return_pulse, zoom_out_pulse, zoom_in_pulse,
    output algorithm_select, multiple_switches_error, no_switch_selected_error, sel_changed
  );
endinterface

// File: rtl/input_conditioner_key_debouncer.sv
// One active-low key: 2-flop synchroniser, press/release debounce FSM, one-cycle pulse per press.
// Pulse is registered DEBOUNCE_CYCLES+2 edges after the raw press is first sampled.
module key_debouncer
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             pressed;

  assign pressed = ~sync_q[1];
  assign pulse_o = pulse_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= ARMING;
            cnt_q   <= CNT_ONE;
          end
        end
        ARMING: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q <= RELEASING;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASING: begin
          // A re-press before the release is confirmed is the same press: no pulse.
          if (pressed) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces three keys into prioritised command pulses and four switches into a committed selection.
// Key pulses and selection commits land DEBOUNCE_CYCLES+2 edges after the input settles.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input logic                clk,
  input logic                reset,
  input_conditioner_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic [2:0] raw_pulse;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk_i  (clk),
      .reset_i(reset),
      .key_n_i(io.key_n[k]),
      .pulse_o(raw_pulse[k])
    );
  end

  // Losing pulses are dropped, not queued.
  assign io.return_pulse   = raw_pulse[KEY_RETURN];
  assign io.zoom_out_pulse = raw_pulse[KEY_ZOOM_OUT] & ~raw_pulse[KEY_RETURN];
  assign io.zoom_in_pulse  = raw_pulse[KEY_ZOOM_IN] & ~raw_pulse[KEY_ZOOM_OUT] & ~raw_pulse[KEY_RETURN];

  logic [3:0]       sw_meta_q, sw_sync_q;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  sel_t             sel_q, sel_d, sel_prev_q;
  logic             sel_changed_q;

  always_comb begin
    cand_d   = cand_q;
    sw_cnt_d = sw_cnt_q;
    sel_d    = sel_q;
    if (sw_sync_q != cand_q) begin
      cand_d   = sw_sync_q;
      sw_cnt_d = CNT_ONE;
    end else if (sw_cnt_q == CNT_LAST) begin
      sel_d    = decode_sel(cand_q);
      sw_cnt_d = CNT_SAT;
    end else if (sw_cnt_q != CNT_SAT) begin
      sw_cnt_d = sw_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      cand_q        <= '0;
      sw_cnt_q      <= '0;
      sel_q         <= SEL_RESET;
      sel_prev_q    <= SEL_RESET;
      sel_changed_q <= 1'b0;
    end else begin
      sw_meta_q     <= io.sw;
      sw_sync_q     <= sw_meta_q;
      cand_q        <= cand_d;
      sw_cnt_q      <= sw_cnt_d;
      sel_q         <= sel_d;
      sel_prev_q    <= sel_q;
      sel_changed_q <= (sel_q != sel_prev_q);
    end
  end

  assign io.algorithm_select         = sel_q.algorithm_select;
  assign io.multiple_switches_error  = sel_q.multiple_switches_error;
  assign io.no_switch_selected_error = sel_q.no_switch_selected_error;
  assign io.sel_changed              = sel_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed sequences, a switch vector table,
// and randomised traffic checked every cycle against a run-length reference model.
module tb_input_conditioner;

  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a change is accepted once the last D synchronised samples all agree.
  logic [2:0] kpipe[$];
  logic [3:0] spipe[$];
  logic [2:0] khist[$];
  logic [3:0] shist[$];
  logic [2:0] m_held;
  logic [2:0] m_pulse;
  logic [3:0] m_sel, m_sel_last;
  logic       m_sc;
  localparam logic [3:0] SEL_RST = 4'b0001;

  function automatic logic [3:0] ref_decode(input logic [3:0] s);
    logic [1:0] alg;
    int ones;
    alg  = 2'b00;
    ones = 0;
    for (int i = 3; i >= 0; i--) begin
      if (s[i]) begin
        alg = 2'(i);
        ones++;
      end
    end
    return {alg, (ones > 1), (ones == 0)};
  endfunction

  task automatic model_edge();
    logic [2:0] ks, raw;
    logic [3:0] ss;
    bit all_p, all_r, same;
    if (reset) begin
      kpipe.delete(); spipe.delete(); khist.delete(); shist.delete();
      repeat (2) begin
        kpipe.push_back(3'b111);
        spipe.push_back(4'h0);
      end
      m_held = 3'b000; m_pulse = 3'b000; m_sc = 1'b0;
      m_sel = SEL_RST; m_sel_last = SEL_RST;
      return;
    end
    kpipe.push_back(bus.key_n);
    spipe.push_back(bus.sw);
    ks = kpipe.pop_front();
    ss = spipe.pop_front();
    khist.push_back(ks);
    shist.push_back(ss);
    if (khist.size() > D) void'(khist.pop_front());
    if (shist.size() > D) void'(shist.pop_front());
    raw = 3'b000;
    if (khist.size() == D) begin
      for (int k = 0; k < 3; k++) begin
        all_p = 1; all_r = 1;
        for (int j = 0; j < D; j++) begin
          if (khist[j][k]) all_p = 0;
          else             all_r = 0;
        end
        if (!m_held[k] && all_p) begin
          m_held[k] = 1'b1;
          raw[k]    = 1'b1;
        end else if (m_held[k] && all_r) begin
          m_held[k] = 1'b0;
        end
      end
    end
    m_sc       = (m_sel != m_sel_last);
    m_sel_last = m_sel;
    if (shist.size() == D) begin
      same = 1;
      for (int j = 1; j < D; j++) if (shist[j] != shist[0]) same = 0;
      if (same) m_sel = ref_decode(shist[0]);
    end
    m_pulse = raw[0] ? 3'b001 : raw[1] ? 3'b010 : raw[2] ? 3'b100 : 3'b000;
  endtask

  task automatic tick();
    logic [7:0] got, exp;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    got = {bus.zoom_in_pulse, bus.zoom_out_pulse, bus.return_pulse, bus.algorithm_select,
           bus.multiple_switches_error, bus.no_switch_selected_error, bus.sel_changed};
    exp = {m_pulse, m_sel, m_sc};
    check($sformatf("model@%0d", cyc), 32'(got), 32'(exp));
  endtask

  int pcnt[3];
  int pedge[3];
  int sccnt;

  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      pcnt[k]  = 0;
      pedge[k] = 0;
    end
    sccnt = 0;
  endtask

  task automatic seg(input logic [2:0] kn, input logic [3:0] s, input int n);
    for (int i = 1; i <= n; i++) begin
      bus.key_n = kn;
      bus.sw    = s;
      tick();
      if (bus.return_pulse)   begin pcnt[0]++; pedge[0] = i; end
      if (bus.zoom_out_pulse) begin pcnt[1]++; pedge[1] = i; end
      if (bus.zoom_in_pulse)  begin pcnt[2]++; pedge[2] = i; end
      if (bus.sel_changed) sccnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pulses"}, 32'({bus.zoom_in_pulse, bus.zoom_out_pulse, bus.return_pulse}), 0);
    check({tag, "_alg"}, 32'(bus.algorithm_select), 0);
    check({tag, "_mse"}, 32'(bus.multiple_switches_error), 0);
    check({tag, "_nse"}, 32'(bus.no_switch_selected_error), 1);
    check({tag, "_selchg"}, 32'(bus.sel_changed), 0);
  endtask

  typedef struct {
    logic [3:0] sw;
    int         cycles;
    logic [1:0] alg;
    logic       mse;
    logic       nse;
    int         sc;
  } sw_vec_t;

  sw_vec_t tbl[7];

  initial begin
    logic [2:0] kval;
    logic [3:0] sval;
    int krun, srun;

    tbl[0] = '{4'b0001, 10, 2'b00, 1'b0, 1'b0, 1};
    tbl[1] = '{4'b0110, 10, 2'b01, 1'b1, 1'b0, 1};
    tbl[2] = '{4'b0100,  3, 2'b01, 1'b1, 1'b0, 0};
    tbl[3] = '{4'b0110, 10, 2'b01, 1'b1, 1'b0, 0};
    tbl[4] = '{4'b0000, 10, 2'b00, 1'b0, 1'b1, 1};
    tbl[5] = '{4'b1000, 10, 2'b11, 1'b0, 1'b0, 1};
    tbl[6] = '{4'b1100, 10, 2'b10, 1'b1, 1'b0, 1};

    reset     = 1'b1;
    bus.key_n = 3'b111;
    bus.sw    = 4'h0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    seg(3'b111, 4'h0, 8);

    // zoom_in: press, release, press again
    clr(); seg(3'b011, 4'h0, 20);
    check("zi_press1_cnt", pcnt[2], 1);
    check("zi_press1_edge", pedge[2], 6);
    clr(); seg(3'b111, 4'h0, 10);
    check("zi_release_cnt", pcnt[2], 0);
    clr(); seg(3'b011, 4'h0, 20);
    check("zi_press2_cnt", pcnt[2], 1);
    check("zi_press2_edge", pedge[2], 6);
    seg(3'b111, 4'h0, 10);

    // zoom_out bounce then steady press
    clr();
    seg(3'b101, 4'h0, 3); seg(3'b111, 4'h0, 1);
    seg(3'b101, 4'h0, 3); seg(3'b111, 4'h0, 1);
    check("zo_bounce_cnt", pcnt[1], 0);
    clr(); seg(3'b101, 4'h0, 12);
    check("zo_steady_cnt", pcnt[1], 1);
    check("zo_steady_edge", pedge[1], 6);
    seg(3'b111, 4'h0, 10);

    // return: short release while held must not re-trigger
    clr(); seg(3'b110, 4'h0, 10);
    check("ret_first_cnt", pcnt[0], 1);
    check("ret_first_edge", pedge[0], 6);
    clr(); seg(3'b111, 4'h0, 2); seg(3'b110, 4'h0, 10);
    check("ret_glitch_cnt", pcnt[0], 0);
    clr(); seg(3'b111, 4'h0, 8);
    check("ret_release_cnt", pcnt[0], 0);
    clr(); seg(3'b110, 4'h0, 10);
    check("ret_repress_cnt", pcnt[0], 1);
    check("ret_repress_edge", pedge[0], 6);
    seg(3'b111, 4'h0, 10);

    // return and zoom_in together: return wins, zoom_in dropped
    clr(); seg(3'b010, 4'h0, 10);
    check("simul_ret_cnt", pcnt[0], 1);
    check("simul_ret_edge", pedge[0], 6);
    check("simul_zi_cnt", pcnt[2], 0);
    seg(3'b111, 4'h0, 10);

    for (int i = 0; i < 7; i++) begin
      clr();
      seg(3'b111, tbl[i].sw, tbl[i].cycles);
      check($sformatf("sw%0d_alg", i), 32'(bus.algorithm_select), 32'(tbl[i].alg));
      check($sformatf("sw%0d_mse", i), 32'(bus.multiple_switches_error), 32'(tbl[i].mse));
      check($sformatf("sw%0d_nse", i), 32'(bus.no_switch_selected_error), 32'(tbl[i].nse));
      check($sformatf("sw%0d_selchg", i), sccnt, tbl[i].sc);
    end

    // reset while zoom_in is mid-arming, key kept held
    clr(); seg(3'b011, 4'b1100, 4);
    check("rstmid_pre_cnt", pcnt[2], 0);
    reset = 1'b1;
    tick();
    check_reset_vals("rstmid");
    reset = 1'b0;
    clr(); seg(3'b011, 4'b1100, 12);
    check("rstmid_cnt", pcnt[2], 1);
    check("rstmid_edge", pedge[2], 6);
    seg(3'b111, 4'b1100, 10);

    krun = 0; srun = 0; kval = 3'b111; sval = 4'h0;
    for (int r = 0; r < 1500; r++) begin
      if (krun == 0) begin
        kval = 3'($urandom);
        krun = $urandom_range(1, 9);
      end
      if (srun == 0) begin
        sval = 4'($urandom);
        srun = $urandom_range(1, 9);
      end
      reset     = ($urandom_range(0, 299) == 0);
      bus.key_n = kval;
      bus.sw    = sval;
      tick();
      krun--;
      srun--;
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
